// File: rtl/stats_pkg.sv
// Shared widths, defaults and the buffered record type for the stats event arbiter.
package stats_pkg;

    localparam int NUM_SRC_DEF    = 4;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ID_W           = 32;
    localparam int CYCLE_W        = 64;
    // Record source field is sized for up to 256 sources; the top trims it to clog2(NUM_SRC).
    localparam int SRC_W          = 8;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [SRC_W-1:0]   src;
        logic               rd;
        logic               wr;
        logic [CYCLE_W-1:0] cycle;
    } stats_rec_t;

endpackage

// File: rtl/stats_rec_fifo.sv
// Small record buffer; head entry is visible combinationally, zero when empty.
module stats_rec_fifo
    import stats_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  stats_rec_t push_data,
    input  logic       pop,
    output stats_rec_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    stats_rec_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    // Full/empty come from registered occupancy only, so a same-cycle pop never frees a slot.
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr_reg];

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/stats_event_arbiter.sv
// Round-robin arbiter that timestamps and IDs response events into a record buffer.
module stats_event_arbiter
    import stats_pkg::*;
#(
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          enable,
    input  logic [NUM_SRC-1:0]                            ev_valid,
    input  logic [NUM_SRC-1:0]                            ev_rd,
    input  logic [NUM_SRC-1:0]                            ev_wr,
    output logic [NUM_SRC-1:0]                            ev_ready,
    output logic                                          rec_valid,
    input  logic                                          rec_ready,
    output logic [ID_W-1:0]                               rec_id,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] rec_src,
    output logic                                          rec_rd,
    output logic                                          rec_wr,
    output logic [CYCLE_W-1:0]                            rec_cycle,
    output logic [CYCLE_W-1:0]                            global_cycle,
    output logic [31:0]                                   stall_cnt
);

    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [CYCLE_W-1:0] global_cycle_reg;
    logic [ID_W-1:0]    next_id_reg;
    logic [SW-1:0]      ptr_reg;
    logic [31:0]        stall_cnt_reg;
    logic [SW-1:0]      winner;
    logic               any_valid;
    logic               grant;
    logic               fifo_full;
    logic               fifo_empty;
    stats_rec_t         push_rec;
    stats_rec_t         head_rec;

    assign any_valid = |ev_valid;
    // Reset gates the grant so ev_ready is low for the whole reset window.
    assign grant     = reset_n & enable & ~fifo_full & any_valid;
    assign ev_ready  = grant ? (NUM_SRC'(1) << winner) : '0;

    // Round-robin scan: first valid source starting at ptr and wrapping.
    always_comb begin
        int  idx;
        logic found;
        winner = ptr_reg;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(ptr_reg) + k) % NUM_SRC;
            if (!found && ev_valid[idx]) begin
                winner = SW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign push_rec.id    = next_id_reg;
    assign push_rec.src   = SRC_W'(winner);
    assign push_rec.rd    = ev_rd[winner];
    assign push_rec.wr    = ev_wr[winner];
    assign push_rec.cycle = global_cycle_reg;

    stats_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (grant),
        .push_data (push_rec),
        .pop       (rec_ready),
        .head      (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Timestamp, ID, pointer and stall bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            global_cycle_reg <= '0;
            next_id_reg      <= '0;
            ptr_reg          <= '0;
            stall_cnt_reg    <= '0;
        end else begin
            global_cycle_reg <= global_cycle_reg + 1'b1;
            if (grant) begin
                next_id_reg <= next_id_reg + 1'b1;
                ptr_reg     <= (winner == SW'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
            end else if (any_valid && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign rec_valid    = ~fifo_empty;
    assign rec_id       = head_rec.id;
    assign rec_src      = head_rec.src[SW-1:0];
    assign rec_rd       = head_rec.rd;
    assign rec_wr       = head_rec.wr;
    assign rec_cycle    = head_rec.cycle;
    assign global_cycle = global_cycle_reg;
    assign stall_cnt    = stall_cnt_reg;

    generate
        if (SW < SRC_W) begin : g_src_trim
            logic src_hi_unused;
            assign src_hi_unused = ^head_rec.src[SRC_W-1:SW];
        end
    endgenerate

endmodule

// File: tb/tb_stats_event_arbiter.sv
// Randomized and directed bench for stats_event_arbiter against a queue-based reference model.
module tb_stats_event_arbiter;
    import stats_pkg::*;

    localparam int NS    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          rec_ready = 1'b0;
    logic [NS-1:0] ev_valid = '0;
    logic [NS-1:0] ev_rd = '0;
    logic [NS-1:0] ev_wr = '0;
    logic [NS-1:0] ev_ready;
    logic          rec_valid;
    logic [31:0]   rec_id;
    logic [1:0]    rec_src;
    logic          rec_rd;
    logic          rec_wr;
    logic [63:0]   rec_cycle;
    logic [63:0]   global_cycle;
    logic [31:0]   stall_cnt;

    stats_event_arbiter #(
        .NUM_SRC    (NS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .ev_valid     (ev_valid),
        .ev_rd        (ev_rd),
        .ev_wr        (ev_wr),
        .ev_ready     (ev_ready),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_id       (rec_id),
        .rec_src      (rec_src),
        .rec_rd       (rec_rd),
        .rec_wr       (rec_wr),
        .rec_cycle    (rec_cycle),
        .global_cycle (global_cycle),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        longint unsigned id;
        int              src;
        bit              rd;
        bit              wr;
        longint unsigned cyc;
    } mrec_t;

    mrec_t           q[$];
    int              m_ptr;
    longint unsigned m_id;
    longint unsigned m_gc;
    longint unsigned m_stall;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock of checking: entered just after a falling edge with inputs already driven.
    task automatic step();
        int    win;
        bit    grant;
        bit    pop;
        logic [NS-1:0] exp_ready;
        mrec_t r;
        #1;
        win = -1;
        for (int k = 0; k < NS; k++) begin
            int i;
            i = (m_ptr + k) % NS;
            if (win < 0 && ev_valid[i]) win = i;
        end
        grant     = enable && (q.size() < DEPTH) && (win >= 0);
        exp_ready = grant ? (NS'(1) << win) : '0;
        check_val("ev_ready", 64'(ev_ready), 64'(exp_ready));
        check_val("rec_valid", 64'(rec_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check_val("rec_id", 64'(rec_id), q[0].id);
            check_val("rec_src", 64'(rec_src), 64'(q[0].src));
            check_val("rec_rd", 64'(rec_rd), 64'(q[0].rd));
            check_val("rec_wr", 64'(rec_wr), 64'(q[0].wr));
            check_val("rec_cycle", rec_cycle, q[0].cyc);
        end
        check_val("global_cycle", global_cycle, m_gc);
        check_val("stall_cnt", 64'(stall_cnt), m_stall);
        pop = (q.size() > 0) && rec_ready;
        @(posedge clk);
        if (pop) begin
            $display("rec id=%0h src=%0d rd=%0d wr=%0d cyc=%0d", q[0].id, q[0].src, q[0].rd, q[0].wr, q[0].cyc);
            void'(q.pop_front());
        end
        if (grant) begin
            r.id  = m_id;
            r.src = win;
            r.rd  = ev_rd[win];
            r.wr  = ev_wr[win];
            r.cyc = m_gc;
            q.push_back(r);
            m_id  = (m_id + 1) & 64'hFFFF_FFFF;
            m_ptr = (win + 1) % NS;
        end else if (ev_valid != '0 && m_stall < 64'hFFFF_FFFF) begin
            m_stall++;
        end
        m_gc++;
        @(negedge clk);
    endtask

    // Assert reset at a falling edge, check the cleared outputs at once, then release.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_val("rst_ev_ready", 64'(ev_ready), 64'd0);
        check_val("rst_rec_valid", 64'(rec_valid), 64'd0);
        check_val("rst_rec_id", 64'(rec_id), 64'd0);
        check_val("rst_rec_src", 64'(rec_src), 64'd0);
        check_val("rst_rec_flags", 64'({rec_rd, rec_wr}), 64'd0);
        check_val("rst_rec_cycle", rec_cycle, 64'd0);
        check_val("rst_global_cycle", global_cycle, 64'd0);
        check_val("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        q.delete();
        m_ptr   = 0;
        m_id    = 0;
        m_gc    = 0;
        m_stall = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic rand_cycles(input int n, input int en_pct, input int rdy_pct);
        for (int c = 0; c < n; c++) begin
            ev_valid  = NS'($urandom);
            ev_rd     = NS'($urandom);
            ev_wr     = NS'($urandom);
            enable    = ($urandom_range(99) < en_pct);
            rec_ready = ($urandom_range(99) < rdy_pct);
            step();
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // All sources valid, sink always ready: grants rotate 0,1,2,3,0.
        enable = 1'b1; rec_ready = 1'b1; ev_valid = '1;
        for (int c = 0; c < 7; c++) begin
            ev_rd = NS'($urandom); ev_wr = NS'($urandom);
            step();
        end

        // Stalled sink with a single source: fill, then full-and-pop cycle accepts nothing.
        ev_valid = '0; rec_ready = 1'b1;
        repeat (4) step();
        do_reset();
        enable = 1'b1; rec_ready = 1'b0; ev_valid = 4'b0100; ev_rd = 4'b0100; ev_wr = 4'b0000;
        repeat (6) step();
        check_val("stall_after_fill", 64'(stall_cnt), 64'd2);
        rec_ready = 1'b1;
        step();
        ev_valid = '0;
        repeat (6) step();

        // Disabled logging drains three buffered records, then resumes with the next ID.
        do_reset();
        enable = 1'b1; rec_ready = 1'b0; ev_valid = 4'b0010; ev_rd = 4'b0010; ev_wr = 4'b0010;
        repeat (3) step();
        enable = 1'b0; rec_ready = 1'b1; ev_valid = 4'b1111;
        repeat (4) step();
        enable = 1'b1;
        repeat (3) step();
        ev_valid = '0;
        repeat (4) step();

        // ID wraparound from the top of the 32-bit range.
        force dut.next_id_reg = 32'hFFFF_FFFF;
        #1;
        release dut.next_id_reg;
        m_id = 64'hFFFF_FFFF;
        enable = 1'b1; rec_ready = 1'b1; ev_valid = 4'b1001;
        repeat (2) step();
        ev_valid = '0;
        repeat (3) step();

        rand_cycles(300, 85, 60);

        // Mid-stream reset with records buffered.
        enable = 1'b1; rec_ready = 1'b0; ev_valid = 4'b1111;
        repeat (2) step();
        do_reset();
        ev_valid = '0;
        step();

        rand_cycles(300, 90, 40);
        ev_valid = '0; rec_ready = 1'b1;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
